store_buffer: RTL and testbench

- Post-commit store buffer directly downstream of the store byte-lane aligner.
- Accepts word-aligned store data plus a 4-bit byte-select vector from the MEM stage and queues it in a small FIFO.
- Drains entries one at a time to the L1 data cache write port over a req/ack handshake.
- Coalesces back-to-back stores to the same word; flags loads that hit a pending store so the pipeline can stall them.

---
 rtl/store_buffer_pkg.sv | 9 +
 rtl/store_buffer_if.sv | 25 ++
 rtl/store_buffer_byte_merge.sv | 24 ++
 rtl/store_buffer.sv | 112 +++++++++++
 tb/tb_store_buffer.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/store_buffer_pkg.sv
// Shared constants for the post-commit store buffer.
package store_buffer_pkg;

  localparam int SB_DEPTH  = 4;   // default number of entries
  localparam int SB_ADDR_W = 30;  // word address, byte address bits [31:2]
  localparam int SB_BSEL_W = 4;   // one enable per byte lane
  localparam int SB_DATA_W = 32;  // one lane-aligned word

endpackage

// File: rtl/store_buffer_if.sv
// Cache write port of the store buffer: head entry offered with req, taken with ack.
interface store_buffer_if
  import store_buffer_pkg::*;
#(
  parameter int ADDR_W = SB_ADDR_W
) ();

  logic                 cache_wr_req;
  logic [ADDR_W-1:0]    cache_wr_waddr;
  logic [SB_BSEL_W-1:0] cache_wr_bsel;
  logic [SB_DATA_W-1:0] cache_wr_data;
  logic                 cache_wr_ack;

  // The store buffer drives the write; the cache acknowledges it.
  modport master (
    output cache_wr_req, cache_wr_waddr, cache_wr_bsel, cache_wr_data,
    input  cache_wr_ack
  );

  modport slave (
    input  cache_wr_req, cache_wr_waddr, cache_wr_bsel, cache_wr_data,
    output cache_wr_ack
  );

endinterface

// File: rtl/store_buffer_byte_merge.sv
// Combinational 4-lane merge of a new store into an existing entry.
module store_buffer_byte_merge
  import store_buffer_pkg::*;
(
  input  logic [SB_BSEL_W-1:0] old_bsel,
  input  logic [SB_DATA_W-1:0] old_data,
  input  logic [SB_BSEL_W-1:0] new_bsel,
  input  logic [SB_DATA_W-1:0] new_data,
  output logic [SB_BSEL_W-1:0] merged_bsel,
  output logic [SB_DATA_W-1:0] merged_data
);

  assign merged_bsel = old_bsel | new_bsel;

  // Overwrite only the lanes the new store enables.
  always_comb begin
    // NOTE: assign a default before the conditional overwrites so no path leaves the output unassigned (no latch).
    merged_data = old_data;
    for (int i = 0; i < SB_BSEL_W; i++) begin
      if (new_bsel[i]) merged_data[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Post-commit store buffer: FIFO of word stores with youngest-entry coalescing,
// drained to the L1 write port over req/ack, with a load-hit conflict flag.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [ADDR_W-1:0]         st_waddr,
  input  logic [SB_BSEL_W-1:0]      st_bsel,
  input  logic [SB_DATA_W-1:0]      st_wdata,
  input  logic [ADDR_W-1:0]         ld_waddr,
  input  logic                      ld_check,
  output logic                      ld_conflict,
  store_buffer_if.master            cache,
  output logic                      sb_empty,
  output logic [$clog2(DEPTH):0]    sb_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]    waddr;
    logic [SB_BSEL_W-1:0] bsel;
    logic [SB_DATA_W-1:0] data;
  } entry_t;

  entry_t          entry_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]   head_q, tail_q;
  logic [CW-1:0]   count_q, count_next;

  logic [PW-1:0]        youngest;
  logic                 enq, deq, merge_hit, ld_hit;
  logic [SB_BSEL_W-1:0] merged_bsel;
  logic [SB_DATA_W-1:0] merged_data;

  assign youngest  = tail_q - PW'(1);
  assign st_ready  = (count_q != CW'(DEPTH));
  assign enq       = st_valid && st_ready && (st_bsel != '0);
  assign deq       = cache.cache_wr_req && cache.cache_wr_ack;
  // The head is never a merge target: requiring two entries keeps youngest != head.
  assign merge_hit = (count_q >= CW'(2)) && valid_q[youngest] &&
                     (entry_q[youngest].waddr == st_waddr);

  store_buffer_byte_merge u_merge (
    .old_bsel    (entry_q[youngest].bsel),
    .old_data    (entry_q[youngest].data),
    .new_bsel    (st_bsel),
    .new_data    (st_wdata),
    .merged_bsel (merged_bsel),
    .merged_data (merged_data)
  );

  // Occupancy: allocation adds one, drain removes one, a merge leaves it alone.
  always_comb begin
    count_next = count_q;
    if (enq && !merge_hit) count_next = count_next + CW'(1);
    if (deq)               count_next = count_next - CW'(1);
  end

  // Entry storage and head/tail pointers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      // NOTE: the storage is reset, not just the valid bits, because the cache port shows the head entry and must read zero out of reset.
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block sees the pre-edge state.
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (enq) begin
        if (merge_hit) begin
          entry_q[youngest].bsel <= merged_bsel;
          entry_q[youngest].data <= merged_data;
        end else begin
          entry_q[tail_q] <= '{waddr: st_waddr, bsel: st_bsel, data: st_wdata};
          valid_q[tail_q] <= 1'b1;
          tail_q          <= tail_q + PW'(1);
        end
      end
      count_q <= count_next;
    end
  end

  // Loads that hit any pending entry, including a head being acked this cycle.
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].waddr == ld_waddr)) ld_hit = 1'b1;
    end
  end

  assign ld_conflict          = ld_check && ld_hit;
  assign cache.cache_wr_req   = (count_q != '0);
  assign cache.cache_wr_waddr = entry_q[head_q].waddr;
  assign cache.cache_wr_bsel  = entry_q[head_q].bsel;
  assign cache.cache_wr_data  = entry_q[head_q].data;
  assign sb_empty             = (count_q == '0);
  assign sb_count             = count_q;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [29:0] st_waddr = '0;
  logic [3:0]  st_bsel = '0;
  logic [31:0] st_wdata = '0;
  logic [29:0] ld_waddr = '0;
  logic        ld_check = 1'b0;
  logic        ld_conflict;
  logic        sb_empty;
  logic [2:0]  sb_count;

  int n_checks = 0;
  int n_fail   = 0;

  store_buffer_if #(.ADDR_W(30)) cache_if ();

  store_buffer #(.DEPTH(4), .ADDR_W(30)) dut (
    .clock       (clock),
    .reset       (reset),
    .st_valid    (st_valid),
    .st_ready    (st_ready),
    .st_waddr    (st_waddr),
    .st_bsel     (st_bsel),
    .st_wdata    (st_wdata),
    .ld_waddr    (ld_waddr),
    .ld_check    (ld_check),
    .ld_conflict (ld_conflict),
    .cache       (cache_if),
    .sb_empty    (sb_empty),
    .sb_count    (sb_count)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [29:0] wa, input logic [3:0] bs, input logic [31:0] d);
    st_valid = 1'b1;
    st_waddr = wa;
    st_bsel  = bs;
    st_wdata = d;
    tick();
    st_valid = 1'b0;
  endtask

  // Check the presented head, then accept it with a one-cycle ack.
  task automatic drain_one(input string tag, input logic [29:0] wa, input logic [3:0] bs,
                           input logic [31:0] d);
    check({tag, "_req"},   64'(cache_if.cache_wr_req),   64'd1);
    check({tag, "_waddr"}, 64'(cache_if.cache_wr_waddr), 64'(wa));
    check({tag, "_bsel"},  64'(cache_if.cache_wr_bsel),  64'(bs));
    check({tag, "_data"},  64'(cache_if.cache_wr_data),  64'(d));
    cache_if.cache_wr_ack = 1'b1;
    tick();
    cache_if.cache_wr_ack = 1'b0;
  endtask

  logic [29:0] q_addr[$];
  logic [31:0] q_data[$];
  int mcount, idx, drained, cycles;
  bit acc, had_deq;

  initial begin
    cache_if.cache_wr_ack = 1'b0;
    #12 reset = 1'b1;
    tick();

    // Reset state, with a load probing the (invalid, zeroed) entry address.
    ld_check = 1'b1;
    ld_waddr = '0;
    #1;
    check("rst_req",      64'(cache_if.cache_wr_req),   64'd0);
    check("rst_ready",    64'(st_ready),                64'd1);
    check("rst_empty",    64'(sb_empty),                64'd1);
    check("rst_count",    64'(sb_count),                64'd0);
    check("rst_conflict", 64'(ld_conflict),             64'd0);
    check("rst_waddr",    64'(cache_if.cache_wr_waddr), 64'd0);
    check("rst_bsel",     64'(cache_if.cache_wr_bsel),  64'd0);
    check("rst_data",     64'(cache_if.cache_wr_data),  64'd0);
    ld_check = 1'b0;

    // Single store: req the cycle after enqueue, outputs stable while unacked.
    push(30'h10, 4'b0001, 32'h0000_00AB);
    for (int i = 0; i < 3; i++) begin
      check("single_hold_req",   64'(cache_if.cache_wr_req),  64'd1);
      check("single_hold_waddr", 64'(cache_if.cache_wr_waddr), 64'h10);
      check("single_hold_data",  64'(cache_if.cache_wr_data), 64'hAB);
      tick();
    end
    drain_one("single", 30'h10, 4'b0001, 32'h0000_00AB);
    check("single_empty", 64'(sb_empty), 64'd1);
    check("single_req_off", 64'(cache_if.cache_wr_req), 64'd0);

    // A store with no byte enables is dropped.
    push(30'h77, 4'b0000, 32'hDEAD_BEEF);
    check("bsel0_count", 64'(sb_count), 64'd0);

    // Merge into the youngest entry.
    push(30'h20, 4'b1111, 32'h1111_1111);
    push(30'h30, 4'b0011, 32'h0000_2222);
    push(30'h30, 4'b1100, 32'h3333_0000);
    check("merge_count", 64'(sb_count), 64'd2);
    drain_one("merge_e0", 30'h20, 4'b1111, 32'h1111_1111);
    drain_one("merge_e1", 30'h30, 4'b1111, 32'h3333_2222);
    check("merge_empty", 64'(sb_empty), 64'd1);

    // Head is not a merge target.
    push(30'h40, 4'b0001, 32'h0000_00AA);
    push(30'h40, 4'b0010, 32'h0000_BB00);
    check("nohead_count", 64'(sb_count), 64'd2);
    drain_one("nohead_e0", 30'h40, 4'b0001, 32'h0000_00AA);
    drain_one("nohead_e1", 30'h40, 4'b0010, 32'h0000_BB00);

    // Fill, refuse a fifth store, then stream with ack every cycle.
    for (int k = 0; k < 4; k++) begin
      push(30'h100 + 30'(k), 4'b1111, 32'hC0DE_0000 + 32'(k));
      q_addr.push_back(30'h100 + 30'(k));
      q_data.push_back(32'hC0DE_0000 + 32'(k));
    end
    check("full_count", 64'(sb_count), 64'd4);
    check("full_ready", 64'(st_ready), 64'd0);
    push(30'h1FF, 4'b1111, 32'hFFFF_FFFF);
    check("full_reject_count", 64'(sb_count), 64'd4);
    check("full_head_kept", 64'(cache_if.cache_wr_waddr), 64'h100);

    mcount = 4; idx = 0; drained = 0; cycles = 0;
    while (drained < 10 && cycles < 40) begin
      cache_if.cache_wr_ack = 1'b1;
      st_valid = (idx < 6);
      st_waddr = 30'h104 + 30'(idx);
      st_bsel  = 4'b1111;
      st_wdata = 32'hC0DE_0004 + 32'(idx);
      #1;
      check("wrap_ready", 64'(st_ready), 64'(mcount < 4));
      check("wrap_count", 64'(sb_count), 64'(mcount));
      acc = (idx < 6) && (mcount < 4);
      had_deq = (mcount > 0);
      if (had_deq) begin
        check("wrap_waddr", 64'(cache_if.cache_wr_waddr), 64'(q_addr[0]));
        check("wrap_data",  64'(cache_if.cache_wr_data),  64'(q_data[0]));
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
        drained++;
      end
      if (acc) begin
        q_addr.push_back(30'h104 + 30'(idx));
        q_data.push_back(32'hC0DE_0004 + 32'(idx));
        idx++;
      end
      mcount = mcount + int'(acc) - int'(had_deq);
      cycles++;
      tick();
    end
    st_valid = 1'b0;
    cache_if.cache_wr_ack = 1'b0;
    check("wrap_drained", 64'(drained), 64'd10);
    check("wrap_final_empty", 64'(sb_empty), 64'd1);

    // Load conflict.
    push(30'h50, 4'b1111, 32'h5050_5050);
    ld_check = 1'b1;
    ld_waddr = 30'h50; #1;
    check("ld_hit", 64'(ld_conflict), 64'd1);
    ld_waddr = 30'h51; #1;
    check("ld_miss", 64'(ld_conflict), 64'd0);
    ld_check = 1'b0; ld_waddr = 30'h50; #1;
    check("ld_nocheck", 64'(ld_conflict), 64'd0);
    ld_check = 1'b1;
    st_valid = 1'b1; st_waddr = 30'h60; st_bsel = 4'b0001; st_wdata = 32'h1;
    cache_if.cache_wr_ack = 1'b1; #1;
    check("ld_hit_during_ack", 64'(ld_conflict), 64'd1);
    ld_waddr = 30'h60; #1;
    check("ld_same_cycle_store", 64'(ld_conflict), 64'd0);
    tick();
    st_valid = 1'b0;
    cache_if.cache_wr_ack = 1'b0;
    check("ld_new_entry_hit", 64'(ld_conflict), 64'd1);
    ld_waddr = 30'h50; #1;
    check("ld_acked_gone", 64'(ld_conflict), 64'd0);
    ld_check = 1'b0;
    drain_one("ld_drain", 30'h60, 4'b0001, 32'h1);

    // Asynchronous reset while a request is pending.
    push(30'h70, 4'b1111, 32'h7);
    push(30'h71, 4'b1111, 32'h8);
    push(30'h72, 4'b1111, 32'h9);
    check("rstmid_pre_count", 64'(sb_count), 64'd3);
    check("rstmid_pre_req", 64'(cache_if.cache_wr_req), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rstmid_req",   64'(cache_if.cache_wr_req), 64'd0);
    check("rstmid_count", 64'(sb_count),              64'd0);
    check("rstmid_ready", 64'(st_ready),              64'd1);
    check("rstmid_empty", 64'(sb_empty),              64'd1);
    #3 reset = 1'b1;
    cache_if.cache_wr_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstmid_no_write", 64'(cache_if.cache_wr_req), 64'd0);
    end
    cache_if.cache_wr_ack = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
